// File: rtl/in_mat_stream_loader_if.sv
// Element stream and BRAM port-A bundle for the input-matrix loader.
// slave = loader side (stream sink, BRAM driver); master = stream source / BRAM observer.
interface in_mat_stream_loader_if #(
    parameter int ELEM_WIDTH     = 16,
    parameter int ELEMS_PER_WORD = 4,
    parameter int ADDR_WIDTH_A   = 8
);
    logic                                 s_valid;
    logic                                 s_ready;
    logic [ELEM_WIDTH-1:0]                s_data;
    logic                                 s_last;
    logic                                 bram_en;
    logic                                 bram_we;
    logic [ADDR_WIDTH_A-1:0]              bram_addr;
    logic [ELEM_WIDTH*ELEMS_PER_WORD-1:0] bram_din;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/in_mat_stream_loader.sv
// Packs a valid/ready element stream into BRAM words written from address 0, then pulses load_done.
// Optional running element checksum output is enabled by defining IN_LOADER_CHECKSUM_EN.
module in_mat_stream_loader #(
    parameter int ELEM_WIDTH     = 16,
    parameter int ELEMS_PER_WORD = 4,
    parameter int ADDR_WIDTH_A   = 8,
    parameter int NUM_WORDS      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    in_mat_stream_loader_if.slave  bus,
    output logic                   busy,
    output logic                   load_done,
    output logic                   err_last
`ifdef IN_LOADER_CHECKSUM_EN
    ,
    output logic [ELEM_WIDTH-1:0]  checksum
`endif
);
    localparam int LANE_W = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                                    state;
    logic [LANE_W-1:0]                         lane_cnt;
    logic [ADDR_WIDTH_A-1:0]                   word_cnt;
    logic [ELEMS_PER_WORD-1:0][ELEM_WIDTH-1:0] lanes;
    logic [ELEMS_PER_WORD-1:0][ELEM_WIDTH-1:0] packed_word;
    logic                                      accept;
    logic                                      last_lane;
    logic                                      last_word;
    logic                                      word_done;
    logic                                      final_elem;

    assign bus.s_ready = (state == LOAD);
    assign busy        = (state != IDLE);
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_lane   = (lane_cnt == LANE_W'(ELEMS_PER_WORD - 1));
    assign last_word   = (word_cnt == ADDR_WIDTH_A'(NUM_WORDS - 1));
    assign word_done   = last_lane || bus.s_last;
    assign final_elem  = last_lane && last_word;

    // NOTE: copy the whole buffer before the indexed lane write so every bit has a value on every path (no latch).
    always_comb begin
        packed_word           = lanes;
        packed_word[lane_cnt] = bus.s_data;
    end

    // NOTE: the lane buffer is reset along with the control state so an aborted load leaves no stale lanes behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lane_cnt      <= '0;
            word_cnt      <= '0;
            lanes         <= '0;
            err_last      <= 1'b0;
            load_done     <= 1'b0;
            bus.bram_en   <= 1'b0;
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
`ifdef IN_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
            bus.bram_en <= 1'b0;
            bus.bram_we <= 1'b0;
            load_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lane_cnt <= '0;
                        word_cnt <= '0;
                        lanes    <= '0;
                        err_last <= 1'b0;
`ifdef IN_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
`ifdef IN_LOADER_CHECKSUM_EN
                        checksum <= checksum + bus.s_data;
`endif
                        // s_last must coincide exactly with the last lane of the last word.
                        if (bus.s_last != final_elem)
                            err_last <= 1'b1;
                        if (word_done) begin
                            bus.bram_en   <= 1'b1;
                            bus.bram_we   <= 1'b1;
                            bus.bram_addr <= word_cnt;
                            bus.bram_din  <= packed_word;
                            lanes         <= '0;
                            lane_cnt      <= '0;
                            if (bus.s_last || last_word)
                                state <= FLUSH;
                            else
                                word_cnt <= word_cnt + 1'b1;
                        end else begin
                            lanes    <= packed_word;
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    load_done <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_in_mat_stream_loader.sv
// Scoreboard bench for in_mat_stream_loader: a list-level model predicts BRAM writes and completions.
// Define IN_LOADER_CHECKSUM_EN for both RTL and bench to also check the checksum port.
module tb_in_mat_stream_loader;
    localparam int EW    = 16;
    localparam int EPW   = 4;
    localparam int AW    = 8;
    localparam int NW    = 4;
    localparam int DW    = EW * EPW;
    localparam int TOTAL = NW * EPW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, load_done, err_last;
`ifdef IN_LOADER_CHECKSUM_EN
    logic [EW-1:0] checksum;
`endif

    in_mat_stream_loader_if #(.ELEM_WIDTH(EW), .ELEMS_PER_WORD(EPW), .ADDR_WIDTH_A(AW)) bus ();

    in_mat_stream_loader #(
        .ELEM_WIDTH(EW), .ELEMS_PER_WORD(EPW), .ADDR_WIDTH_A(AW), .NUM_WORDS(NW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .load_done(load_done),
        .err_last(err_last)
`ifdef IN_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          err;
        logic [EW-1:0] csum;
    } done_t;

    wr_t           wr_q[$];
    done_t         done_q[$];
    logic [EW-1:0] stim_data[$];
    logic          stim_last[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int unsigned   last_acc_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        check({tag, "_bram_en"}, 64'(bus.bram_en), 64'd0);
        check({tag, "_bram_we"}, 64'(bus.bram_we), 64'd0);
        check({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
        check({tag, "_bram_din"}, 64'(bus.bram_din), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_load_done"}, 64'(load_done), 64'd0);
        check({tag, "_err_last"}, 64'(err_last), 64'd0);
`ifdef IN_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a write or a completion.
    initial begin
        wr_t   w;
        done_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.bram_en) begin
                    check("bram_we_with_en", 64'(bus.bram_we), 64'd1);
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h while no write was expected",
                                 bus.bram_addr, bus.bram_din);
                    end else begin
                        w = wr_q.pop_front();
                        check("bram_addr", 64'(bus.bram_addr), 64'(w.addr));
                        check("bram_din", 64'(bus.bram_din), 64'(w.data));
                    end
                end else begin
                    check("bram_we_without_en", 64'(bus.bram_we), 64'd0);
                end
                if (load_done) begin
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_load_done: pulse while no completion was expected");
                    end else begin
                        d = done_q.pop_front();
                        check("err_last_at_done", 64'(err_last), 64'(d.err));
                        check("done_latency", 64'(cyc - last_acc_cyc), 64'd2);
`ifdef IN_LOADER_CHECKSUM_EN
                        check("checksum_at_done", 64'(checksum), 64'(d.csum));
`endif
                    end
                end
            end
        end
    end

    // Reference model: the matrix ends at the first s_last or at element TOTAL-1; elements are grouped
    // EPW at a time into words, unfilled lanes zero. An aborted load only writes its completed words.
    task automatic model_load(input int abort_after, output int n_send);
        int          stop;
        int          nw;
        int          j;
        int unsigned sum;
        wr_t         w;
        done_t       d;
        stop = stim_data.size() - 1;
        for (int i = 0; i < stim_data.size(); i++) begin
            if (stim_last[i] || i == TOTAL - 1) begin
                stop = i;
                break;
            end
        end
        n_send = (abort_after > 0) ? abort_after : stop + 1;
        nw     = (abort_after > 0) ? abort_after / EPW : stop / EPW + 1;
        for (int wi = 0; wi < nw; wi++) begin
            w.addr = AW'(wi);
            w.data = '0;
            for (int k = 0; k < EPW; k++) begin
                j = wi * EPW + k;
                if (j <= stop)
                    w.data[k*EW +: EW] = stim_data[j];
            end
            wr_q.push_back(w);
        end
        if (abort_after == 0) begin
            sum = 0;
            for (int i = 0; i <= stop; i++)
                sum += stim_data[i];
            d.err  = (stop != TOTAL - 1) || !stim_last[stop];
            d.csum = EW'(sum);
            done_q.push_back(d);
        end
    endtask

    task automatic set_stream(input logic [EW-1:0] base, input int n, input int last_pos, input bit const_val);
        stim_data.delete();
        stim_last.delete();
        for (int i = 0; i < n; i++) begin
            stim_data.push_back(const_val ? base : base + EW'(i));
            stim_last.push_back(i == last_pos);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 idle every other cycle, 2 random idles.
    task automatic run_load(input int gap_mode, input int abort_after, input bit start_in_load);
        int n_send;
        int idx;
        int budget;
        bit gap;
        bit toggle;
        model_load(abort_after, n_send);
        @(negedge clk);
        check("idle_s_ready", 64'(bus.s_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", 64'(busy), 64'd1);
        check("load_s_ready", 64'(bus.s_ready), 64'd1);
        check("start_clears_err", 64'(err_last), 64'd0);
        idx    = 0;
        budget = 0;
        toggle = 1'b0;
        while (idx < n_send && budget < 2000) begin
            case (gap_mode)
                1:       gap = toggle;
                2:       gap = ($urandom_range(0, 2) == 0);
                default: gap = 1'b0;
            endcase
            toggle = ~toggle;
            if (gap) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = stim_data[idx];
                bus.s_last  = stim_last[idx];
            end
            start = start_in_load && (idx == 2);
            if (bus.s_valid && bus.s_ready) begin
                idx++;
                last_acc_cyc = cyc;
            end
            @(negedge clk);
            budget++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        start       = 1'b0;
        if (budget >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d of %0d elements", idx, n_send);
        end
        if (abort_after > 0) begin
            #1 rst = 1'b1;
            repeat (2) @(negedge clk);
            check_all_zero("abort");
            check("abort_pending_writes", 64'(wr_q.size()), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            check_all_zero("after_abort");
        end else begin
            budget = 0;
            while ((wr_q.size() != 0 || done_q.size() != 0) && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            check("load_drained", 64'(wr_q.size() + done_q.size()), 64'd0);
            wr_q.delete();
            done_q.delete();
            @(negedge clk);
            check("post_load_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lp;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Reset with toggling inputs, then the first cycle after release.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.s_valid = i[0];
            start       = ~i[0];
            bus.s_data  = EW'(16'h1234 + i);
            #1 check_all_zero("in_reset");
        end
        @(negedge clk);
        start       = 1'b0;
        bus.s_valid = 1'b0;
        rst         = 1'b0;
        #1 check_all_zero("release");
        @(negedge clk);
        check_all_zero("first_cycle_after_reset");

        set_stream(16'h0001, 16, 15, 1'b0);
        run_load(0, 0, 1'b0);
        set_stream(16'h0001, 16, 15, 1'b0);
        run_load(1, 0, 1'b0);
        set_stream(16'h0001, 16, 5, 1'b0);
        run_load(0, 0, 1'b0);
        set_stream(16'h0001, 16, 15, 1'b0);
        run_load(0, 5, 1'b1);
        set_stream(16'h0011, 16, 15, 1'b0);
        run_load(0, 0, 1'b0);
        set_stream(16'hFFFF, 16, 15, 1'b1);
        run_load(0, 0, 1'b0);
        set_stream(16'h0001, 16, -1, 1'b0);
        run_load(1, 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            n  = $urandom_range(1, TOTAL);
            lp = (n < TOTAL || $urandom_range(0, 1) == 1) ? n - 1 : -1;
            stim_data.delete();
            stim_last.delete();
            for (int i = 0; i < n; i++) begin
                stim_data.push_back(EW'($urandom));
                stim_last.push_back(i == lp);
            end
            run_load(2, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
